// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared MEM/WB types: payload layout at default widths and the stage occupancy encoding.
package mem_wb_pipe_stage_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [XLEN_DEF-1:0]   alu_result;
        logic [XLEN_DEF-1:0]   mem_rdata;
        logic [REG_AW_DEF-1:0] rd;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/mem_wb_skid_buf.sv
// Valid/ready holding register for one MEM/WB payload, with an optional second (skid)
// entry enabled by defining MEM_WB_SKID_EN.
module mem_wb_skid_buf
    import mem_wb_pipe_stage_pkg::*;
#(
    parameter type T = mem_wb_payload_t
) (
    input  logic clk,
    input  logic reset,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    occ_e r_state;
    T     r_main;
    logic w_in_xfer;
    logic w_out_xfer;

`ifdef MEM_WB_SKID_EN
    T     r_skid;

    // Ready depends only on state, so the upstream path never sees i_ready.
    assign o_ready = (r_state != ST_TWO);
`else
    assign o_ready = (r_state == ST_EMPTY) || i_ready;
`endif

    assign o_valid    = (r_state != ST_EMPTY);
    assign o_data     = r_main;
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = o_valid && i_ready;

    // NOTE: every register here updates with <= so all reads in this block see
    // pre-edge values; mixing in = would make the skid->main move order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            // NOTE: payload registers are reset as well because their value is
            // observable on the outputs even while the entry is invalid.
            r_main  <= '0;
`ifdef MEM_WB_SKID_EN
            r_skid  <= '0;
`endif
        end else if (i_flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main  <= i_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= i_data;
                    end else if (w_out_xfer) begin
                        r_state <= ST_EMPTY;
`ifdef MEM_WB_SKID_EN
                    end else if (w_in_xfer) begin
                        r_skid  <= i_data;
                        r_state <= ST_TWO;
`endif
                    end
                end
`ifdef MEM_WB_SKID_EN
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
`endif
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline register with x0 write suppression, write-back mux and a saturating
// stall counter. Define MEM_WB_SKID_EN for the two-entry (skid) variant.
module mem_wb_pipe_stage
    import mem_wb_pipe_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_mem_rdata,
    input  logic [REG_AW-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_memtoreg,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_mem_rdata,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_wb_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Same field order as mem_wb_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   mem_rdata;
        logic [REG_AW-1:0] rd;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    payload_t         w_in;
    payload_t         w_out;
    logic             w_out_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in = '{
        regwrite:   in_regwrite,
        memtoreg:   in_memtoreg,
        alu_result: in_alu_result,
        mem_rdata:  in_mem_rdata,
        rd:         in_rd
    };

    mem_wb_skid_buf #(
        .T (payload_t)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in),
        .o_valid (w_out_valid),
        .i_ready (out_ready),
        .o_data  (w_out)
    );

    assign out_valid      = w_out_valid;
    assign out_regwrite   = w_out_valid && w_out.regwrite && (w_out.rd != '0);
    assign out_memtoreg   = w_out.memtoreg;
    assign out_alu_result = w_out.alu_result;
    assign out_mem_rdata  = w_out.mem_rdata;
    assign out_rd         = w_out.rd;
    assign out_wb_data    = w_out.memtoreg ? w_out.mem_rdata : w_out.alu_result;

    // Flush deliberately does not clear the counter; only reset does.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
